// File: rtl/la_vskid.sv
// la_vskid: two-entry registered skid buffer for a vector bus.
// Every output (z, z_valid, a_ready, count) comes straight from a flop.
module la_vskid #(
  parameter int N    = 1,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic         a_valid,
  output logic         a_ready,
  output logic [N-1:0] z,
  output logic         z_valid,
  input  logic         z_ready,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam bit PROP_IS_DEFAULT = (PROP == "DEFAULT");

  state_t       state_reg;
  state_t       state_next;
  logic         a_ready_reg;
  logic         z_valid_reg;
  logic         in_xfer;
  logic         out_xfer;
  logic         m_load_a;
  logic         m_load_s;
  logic         s_load_a;
  logic [N-1:0] m_reg;
  logic [N-1:0] s_reg;

  // Handshakes use the registered ready/valid, so no input reaches an output.
  assign in_xfer  = a_valid & a_ready_reg;
  assign out_xfer = z_valid_reg & z_ready;

  always_comb begin
    state_next = state_reg;
    m_load_a   = 1'b0;
    m_load_s   = 1'b0;
    s_load_a   = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (in_xfer) begin
          m_load_a   = 1'b1;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && !out_xfer) begin
          s_load_a   = 1'b1;
          state_next = ST_FULL;
        end else if (in_xfer && out_xfer) begin
          m_load_a   = 1'b1;
        end else if (out_xfer) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // a_ready is low here, so only the drain of M can happen.
        if (out_xfer) begin
          m_load_s   = 1'b1;
          state_next = ST_ONE;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_EMPTY;
      a_ready_reg <= 1'b0;
      z_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_ready_reg <= (state_next != ST_FULL);
      z_valid_reg <= (state_next != ST_EMPTY);
    end
  end

  // Non-default properties are retargeted to vendor cells by hierarchy name;
  // the generic per-bit flop pair below is the reference implementation.
  if (!PROP_IS_DEFAULT) begin : g_prop_custom
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    logic m_bit_reg;
    logic s_bit_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        m_bit_reg <= 1'b0;
        s_bit_reg <= 1'b0;
      end else begin
        if (m_load_a) begin
          m_bit_reg <= a[gi];
        end else if (m_load_s) begin
          m_bit_reg <= s_bit_reg;
        end
        if (s_load_a) begin
          s_bit_reg <= a[gi];
        end
      end
    end

    assign m_reg[gi] = m_bit_reg;
    assign s_reg[gi] = s_bit_reg;
  end

  assign z       = m_reg;
  assign z_valid = z_valid_reg;
  assign a_ready = a_ready_reg;
  assign count   = state_reg;

endmodule

// File: tb/tb_la_vskid.sv
// Scoreboard bench for la_vskid: directed traffic on an 8-bit instance,
// random traffic on 1-bit and 33-bit instances.
module tb_la_vskid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit rand_go  = 1'b0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 1 : 33;

    logic         rst     = 1'b1;
    logic         rst_q   = 1'b1;
    logic [W-1:0] a       = '0;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [W-1:0] z;
    logic         z_valid;
    logic         z_ready = 1'b0;
    logic [1:0]   count;
    logic [32:0]  q[$];
    int           out_cnt = 0;
    bit           done    = 1'b0;

    la_vskid #(.N(W)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .z       (z),
      .z_valid (z_valid),
      .z_ready (z_ready),
      .count   (count)
    );

    always @(posedge clk) rst_q <= rst;

    // Monitor: compare outputs to the queue model, then apply this cycle's transfers.
    always @(negedge clk) begin
      int sz;
      sz = q.size();
      chk($sformatf("u%0d_count", gi), 33'(count), 33'(sz));
      chk($sformatf("u%0d_z_valid", gi), 33'(z_valid), 33'(sz != 0));
      chk($sformatf("u%0d_a_ready", gi), 33'(a_ready), 33'(!rst_q && sz < 2));
      if (sz != 0)
        chk($sformatf("u%0d_z_data", gi), 33'(z), q[0]);
      else if (rst_q)
        chk($sformatf("u%0d_z_reset", gi), 33'(z), 33'd0);
      if (rst) begin
        q.delete();
      end else begin
        if (a_valid && a_ready) q.push_back(33'(a));
        if (z_valid && z_ready) begin
          out_cnt++;
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL u%0d_spurious_output actual=0x%0h required=none", gi, z);
          end else begin
            void'(q.pop_front());
          end
        end
      end
    end

    if (gi != 0) begin : g_rand
      initial begin
        int acc;
        int cyc;
        bit xfer;
        wait (rand_go);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
          @(negedge clk);
          xfer = a_valid && a_ready;
          @(posedge clk);
          #1;
          cyc++;
          if (xfer) acc++;
          if (!a_valid || xfer) begin
            a_valid = ($urandom_range(0, 1) == 1);
            if (a_valid) a = W'({$urandom(), $urandom()});
            else         a = 'x;
          end
          z_ready = ($urandom_range(0, 1) == 1);
        end
        a_valid = 1'b0;
        z_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk($sformatf("u%0d_accepted", gi), 33'(acc), 33'd1000);
        chk($sformatf("u%0d_delivered", gi), 33'(out_cnt), 33'd1000);
        done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wait_cyc;

    // Reset held for 3 cycles with a_valid asserted.
    g_dut[0].a       = 8'h77;
    g_dut[0].a_valid = 1'b1;
    g_dut[0].z_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_z_valid", 33'(g_dut[0].z_valid), 33'd0);
      chk("rst_a_ready", 33'(g_dut[0].a_ready), 33'd0);
      chk("rst_count",   33'(g_dut[0].count),   33'd0);
    end
    g_dut[0].rst = 1'b0;
    tick();
    chk("release_a_ready", 33'(g_dut[0].a_ready), 33'd1);
    chk("release_count",   33'(g_dut[0].count),   33'd0);
    tick();
    chk("first_word_valid", 33'(g_dut[0].z_valid), 33'd1);
    chk("first_word_data",  33'(g_dut[0].z),       33'h77);
    g_dut[0].a_valid = 1'b0;
    tick();
    chk("first_word_drain", 33'(g_dut[0].count), 33'd0);

    // Streaming 0x01..0x10, no bubbles.
    for (int i = 1; i <= 16; i++) begin
      g_dut[0].a       = 8'(i);
      g_dut[0].a_valid = 1'b1;
      tick();
      chk("stream_valid", 33'(g_dut[0].z_valid), 33'd1);
      chk("stream_data",  33'(g_dut[0].z),       33'(i));
      chk("stream_count", 33'(g_dut[0].count),   33'd1);
    end
    g_dut[0].a_valid = 1'b0;
    tick();
    chk("stream_drain", 33'(g_dut[0].count), 33'd0);

    // Backpressure fill to FULL, then drain.
    g_dut[0].z_ready = 1'b0;
    g_dut[0].a       = 8'hA5;
    g_dut[0].a_valid = 1'b1;
    tick();
    chk("bp_count1",   33'(g_dut[0].count),   33'd1);
    chk("bp_a_ready1", 33'(g_dut[0].a_ready), 33'd1);
    g_dut[0].a = 8'h5A;
    tick();
    chk("bp_count2",   33'(g_dut[0].count),   33'd2);
    chk("bp_a_ready2", 33'(g_dut[0].a_ready), 33'd0);
    g_dut[0].a_valid = 1'b0;
    repeat (3) begin
      tick();
      chk("bp_hold_z", 33'(g_dut[0].z), 33'hA5);
    end
    g_dut[0].z_ready = 1'b1;
    tick();
    chk("bp_drain1_z",     33'(g_dut[0].z),     33'h5A);
    chk("bp_drain1_count", 33'(g_dut[0].count), 33'd1);
    tick();
    chk("bp_drain2_count", 33'(g_dut[0].count),   33'd0);
    chk("bp_drain2_valid", 33'(g_dut[0].z_valid), 33'd0);

    // Simultaneous in/out in ONE for 20 cycles.
    g_dut[0].z_ready = 1'b0;
    g_dut[0].a       = 8'h30;
    g_dut[0].a_valid = 1'b1;
    tick();
    g_dut[0].z_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      g_dut[0].a = 8'(8'h30 + i);
      tick();
      chk("sim_count", 33'(g_dut[0].count), 33'd1);
      chk("sim_data",  33'(g_dut[0].z),     33'(8'h30 + i));
    end
    g_dut[0].a_valid = 1'b0;
    tick();
    chk("sim_drain", 33'(g_dut[0].count), 33'd0);

    // Reset while FULL discards both words.
    g_dut[0].z_ready = 1'b0;
    g_dut[0].a       = 8'h11;
    g_dut[0].a_valid = 1'b1;
    tick();
    g_dut[0].a = 8'h22;
    tick();
    g_dut[0].a_valid = 1'b0;
    chk("mr_full", 33'(g_dut[0].count), 33'd2);
    g_dut[0].rst = 1'b1;
    tick();
    chk("mr_count",   33'(g_dut[0].count),   33'd0);
    chk("mr_z_valid", 33'(g_dut[0].z_valid), 33'd0);
    chk("mr_a_ready", 33'(g_dut[0].a_ready), 33'd0);
    chk("mr_z",       33'(g_dut[0].z),       33'd0);
    g_dut[0].rst     = 1'b0;
    g_dut[0].z_ready = 1'b1;
    tick();
    chk("mr_release_a_ready", 33'(g_dut[0].a_ready), 33'd1);
    repeat (3) begin
      tick();
      chk("mr_no_stale", 33'(g_dut[0].z_valid), 33'd0);
    end

    // Random traffic on the 1-bit and 33-bit instances.
    rand_go  = 1'b1;
    wait_cyc = 0;
    while (!(g_dut[1].done && g_dut[2].done) && wait_cyc < 50000) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (!(g_dut[1].done && g_dut[2].done)) begin
      checks++;
      failures++;
      $display("FAIL random_timeout actual=%0d_cycles required=completion", wait_cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
